// File: rtl/j1_wb_cpu.sv
// J1 16-bit Forth stack CPU with Wishbone classic code (wbc) and data (wbd) master ports.
// Optional build macro J1_WB_UNSIGNED_LT_EN turns ALU op F into an unsigned N<T compare.
module j1_wb_cpu #(
  parameter int DSTACK_DEPTH = 32,
  parameter int RSTACK_DEPTH = 32
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  output logic [15:0] wbc_adr_o,
  input  logic [15:0] wbc_dat_i,
  output logic [15:0] wbc_dat_o,
  output logic        wbc_we_o,
  output logic [1:0]  wbc_sel_o,
  output logic        wbc_cyc_o,
  output logic        wbc_stb_o,
  input  logic        wbc_ack_i,
  output logic [15:0] wbd_adr_o,
  input  logic [15:0] wbd_dat_i,
  output logic [15:0] wbd_dat_o,
  output logic        wbd_we_o,
  output logic [1:0]  wbd_sel_o,
  output logic        wbd_cyc_o,
  output logic        wbd_stb_o,
  input  logic        wbd_ack_i
);

  localparam int DW = $clog2(DSTACK_DEPTH);
  localparam int RW = $clog2(RSTACK_DEPTH);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_DATA} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_insn;
  logic [12:0] r_pc;
  logic [15:0] r_t;
  logic [DW-1:0] r_dsp;
  logic [RW-1:0] r_rsp;
  logic [15:0] r_dstack [0:DSTACK_DEPTH-1];
  logic [15:0] r_rstack [0:RSTACK_DEPTH-1];

  logic [15:0] w_n;
  logic [15:0] w_r;
  logic [12:0] w_pc_inc;
  logic [15:0] w_alu;
  logic        w_is_alu;
  logic        w_mem_rd;
  logic        w_mem_wr;
  logic        w_mem;
  logic        w_commit;
  logic [12:0] w_pc_next;
  logic [15:0] w_t_next;
  logic [DW-1:0] w_dsp_next;
  logic [RW-1:0] w_rsp_next;
  logic        w_dwe;
  logic [15:0] w_dwdata;
  logic        w_rwe;
  logic [15:0] w_rwdata;

  assign w_n      = r_dstack[r_dsp];
  assign w_r      = r_rstack[r_rsp];
  assign w_pc_inc = r_pc + 13'd1;
  assign w_is_alu = (r_insn[15:13] == 3'b011);
  assign w_mem_rd = w_is_alu && (r_insn[11:8] == 4'hC);
  assign w_mem_wr = w_is_alu && r_insn[5];
  assign w_mem    = w_mem_rd || w_mem_wr;

  // A data access defers every architectural update until the slave acks.
  assign w_commit = ((r_state == S_EXEC) && !w_mem) ||
                    ((r_state == S_DATA) && wbd_ack_i);

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FETCH: if (wbc_ack_i) w_state_next = S_EXEC;
      S_EXEC:  w_state_next = w_mem ? S_DATA : S_FETCH;
      S_DATA:  if (wbd_ack_i) w_state_next = S_FETCH;
      default: w_state_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_alu = r_t;
    case (r_insn[11:8])
      4'h0: w_alu = r_t;
      4'h1: w_alu = w_n;
      4'h2: w_alu = r_t + w_n;
      4'h3: w_alu = r_t & w_n;
      4'h4: w_alu = r_t | w_n;
      4'h5: w_alu = r_t ^ w_n;
      4'h6: w_alu = ~r_t;
      4'h7: w_alu = (w_n == r_t) ? 16'hFFFF : 16'h0000;
      4'h8: w_alu = ($signed(w_n) < $signed(r_t)) ? 16'hFFFF : 16'h0000;
      4'h9: w_alu = w_n >> r_t[3:0];
      4'hA: w_alu = r_t - 16'd1;
      4'hB: w_alu = w_r;
      4'hC: w_alu = r_t;
      4'hD: w_alu = w_n << r_t[3:0];
      4'hE: w_alu = 16'({r_dsp, r_rsp});
`ifdef J1_WB_UNSIGNED_LT_EN
      4'hF: w_alu = (w_n < r_t) ? 16'hFFFF : 16'h0000;
`else
      4'hF: w_alu = ($signed(w_n) < $signed(r_t)) ? 16'hFFFF : 16'h0000;
`endif
      default: w_alu = r_t;
    endcase
  end

  always_comb begin
    w_pc_next  = w_pc_inc;
    w_t_next   = r_t;
    w_dsp_next = r_dsp;
    w_rsp_next = r_rsp;
    w_dwe      = 1'b0;
    w_dwdata   = r_t;
    w_rwe      = 1'b0;
    w_rwdata   = r_t;
    if (r_insn[15]) begin
      w_t_next   = {1'b0, r_insn[14:0]};
      w_dsp_next = r_dsp + DW'(1);
      w_dwe      = 1'b1;
    end else begin
      case (r_insn[14:13])
        2'b00: w_pc_next = r_insn[12:0];
        2'b01: begin
          w_t_next   = w_n;
          w_dsp_next = r_dsp - DW'(1);
          if (r_t == 16'h0000) w_pc_next = r_insn[12:0];
        end
        2'b10: begin
          w_rsp_next = r_rsp + RW'(1);
          w_rwe      = 1'b1;
          w_rwdata   = {3'b000, w_pc_inc};
          w_pc_next  = r_insn[12:0];
        end
        default: begin
          // Store-and-fetch together performs only the write; T then takes N.
          if (w_mem_wr && w_mem_rd) w_t_next = w_n;
          else if (w_mem_rd)       w_t_next = wbd_dat_i;
          else                     w_t_next = w_alu;
          w_dsp_next = r_dsp + {{(DW-2){r_insn[1]}}, r_insn[1:0]};
          w_rsp_next = r_rsp + {{(RW-2){r_insn[3]}}, r_insn[3:2]};
          w_dwe      = r_insn[7];
          w_rwe      = r_insn[6];
          if (r_insn[12]) w_pc_next = w_r[12:0];
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      r_insn <= 16'h0000;
      r_pc   <= 13'd0;
      r_t    <= 16'h0000;
      r_dsp  <= '0;
      r_rsp  <= '0;
    end else begin
      if ((r_state == S_FETCH) && wbc_ack_i) r_insn <= wbc_dat_i;
      if (w_commit) begin
        r_pc  <= w_pc_next;
        r_t   <= w_t_next;
        r_dsp <= w_dsp_next;
        r_rsp <= w_rsp_next;
      end
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (w_commit && w_dwe) r_dstack[w_dsp_next] <= w_dwdata;
    if (w_commit && w_rwe) r_rstack[w_rsp_next] <= w_rwdata;
  end

  // Strobes are gated by reset so an in-flight cycle drops the instant reset rises.
  assign wbc_cyc_o = (r_state == S_FETCH) && !sys_rst_i;
  assign wbc_stb_o = wbc_cyc_o;
  assign wbc_adr_o = {2'b00, r_pc, 1'b0};
  assign wbc_dat_o = 16'h0000;
  assign wbc_we_o  = 1'b0;
  assign wbc_sel_o = 2'b11;

  assign wbd_cyc_o = (r_state == S_DATA) && !sys_rst_i;
  assign wbd_stb_o = wbd_cyc_o;
  assign wbd_adr_o = wbd_cyc_o ? r_t : 16'h0000;
  assign wbd_we_o  = wbd_cyc_o && w_mem_wr;
  assign wbd_dat_o = wbd_we_o ? w_n : 16'h0000;
  assign wbd_sel_o = 2'b11;

endmodule

// File: tb/tb_j1_wb_cpu.sv
// Directed bench for j1_wb_cpu: small ROM programs, RAM/I-O slave with configurable wait states.
module tb_j1_wb_cpu;
  logic        sys_clk_i = 1'b0;
  logic        sys_rst_i = 1'b1;
  logic [15:0] wbc_adr_o, wbc_dat_i, wbc_dat_o;
  logic        wbc_we_o, wbc_cyc_o, wbc_stb_o, wbc_ack_i;
  logic [1:0]  wbc_sel_o;
  logic [15:0] wbd_adr_o, wbd_dat_i, wbd_dat_o;
  logic        wbd_we_o, wbd_cyc_o, wbd_stb_o, wbd_ack_i;
  logic [1:0]  wbd_sel_o;

  j1_wb_cpu dut (
    .sys_clk_i(sys_clk_i), .sys_rst_i(sys_rst_i),
    .wbc_adr_o(wbc_adr_o), .wbc_dat_i(wbc_dat_i), .wbc_dat_o(wbc_dat_o),
    .wbc_we_o(wbc_we_o), .wbc_sel_o(wbc_sel_o), .wbc_cyc_o(wbc_cyc_o),
    .wbc_stb_o(wbc_stb_o), .wbc_ack_i(wbc_ack_i),
    .wbd_adr_o(wbd_adr_o), .wbd_dat_i(wbd_dat_i), .wbd_dat_o(wbd_dat_o),
    .wbd_we_o(wbd_we_o), .wbd_sel_o(wbd_sel_o), .wbd_cyc_o(wbd_cyc_o),
    .wbd_stb_o(wbd_stb_o), .wbd_ack_i(wbd_ack_i)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  logic [15:0] rom  [0:8191];
  logic [15:0] dram [0:16383];
  int rom_ptr;
  int io_delay = 0;
  int dcnt = 0;

  assign wbc_ack_i = wbc_cyc_o & wbc_stb_o;
  assign wbc_dat_i = rom[wbc_adr_o[13:1]];
  assign wbd_ack_i = wbd_cyc_o & wbd_stb_o & (dcnt >= (wbd_adr_o[14] ? io_delay : 0));
  assign wbd_dat_i = wbd_adr_o[14] ? 16'hA5C3 : dram[wbd_adr_o[13:0]];

  always @(posedge sys_clk_i) begin
    if (!wbd_cyc_o || wbd_ack_i) dcnt <= 0;
    else dcnt <= dcnt + 1;
    if (wbd_cyc_o && wbd_stb_o && wbd_we_o && wbd_ack_i)
      dram[wbd_adr_o[13:0]] <= wbd_dat_o;
  end

  logic [15:0] f_adr[$];
  int          f_cyc[$];
  logic [15:0] d_adr[$];
  logic        d_we[$];
  logic [15:0] d_dat[$];
  int io_cycles;
  int overlap;
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("check %s ok value=%h", tag, got);
    end
  endtask

  function automatic logic [15:0] fa(input int i);
    return (i < f_adr.size()) ? f_adr[i] : 16'hDEAD;
  endfunction
  function automatic int fc(input int i);
    return (i < f_cyc.size()) ? f_cyc[i] : -1;
  endfunction
  function automatic logic [15:0] da(input int i);
    return (i < d_adr.size()) ? d_adr[i] : 16'hDEAD;
  endfunction
  function automatic logic dw(input int i);
    return (i < d_we.size()) ? d_we[i] : 1'bx;
  endfunction
  function automatic logic [15:0] dd(input int i);
    return (i < d_dat.size()) ? d_dat[i] : 16'hDEAD;
  endfunction

  task automatic org(input int a);
    rom_ptr = a;
  endtask
  task automatic emit(input logic [15:0] w);
    rom[rom_ptr] = w;
    rom_ptr++;
  endtask
  // push a store of the current T to addr (lit addr; N->[T], d-1)
  task automatic emit_store(input logic [15:0] addr);
    emit(16'h8000 | addr);
    emit(16'h6023);
  endtask

  task automatic sample(input int cyc);
    if (wbc_cyc_o && wbc_stb_o && wbc_ack_i) begin
      f_adr.push_back(wbc_adr_o);
      f_cyc.push_back(cyc);
    end
    if (wbd_cyc_o && wbd_stb_o && wbd_ack_i) begin
      d_adr.push_back(wbd_adr_o);
      d_we.push_back(wbd_we_o);
      d_dat.push_back(wbd_dat_o);
    end
    if (wbd_cyc_o && wbd_adr_o == 16'h4000) io_cycles++;
    if (wbc_cyc_o && wbd_cyc_o) overlap++;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 8192; i++) rom[i] = 16'h0000;
    rom_ptr = 0;
  endtask

  // ROM must be loaded while reset is held; releases reset and runs ncyc clocks.
  task automatic run(input int ncyc);
    f_adr.delete(); f_cyc.delete();
    d_adr.delete(); d_we.delete(); d_dat.delete();
    io_cycles = 0;
    @(negedge sys_clk_i);
    sys_rst_i = 1'b0;
    #1;
    sample(0);
    for (int i = 1; i < ncyc; i++) begin
      @(negedge sys_clk_i);
      sample(i);
    end
    sys_rst_i = 1'b1;
  endtask

  initial begin
    overlap = 0;
    clear_rom();
    // Program 1: lit 5, lit 3, + drop; store T, store depth
    emit(16'h8005); emit(16'h8003); emit(16'h6203);
    emit_store(16'h0300);
    emit(16'h6E00);
    emit_store(16'h0301);
    emit(16'h0008);
    repeat (2) @(negedge sys_clk_i);
    check("rst_wbc_cyc", wbc_cyc_o, 1'b0);
    check("rst_wbd_cyc", wbd_cyc_o, 1'b0);
    check("rst_wbc_adr", wbc_adr_o, 16'h0000);
    check("rst_wbd_we_dat", {wbd_we_o, wbd_dat_o, wbd_adr_o}, 33'h0);
    @(negedge sys_clk_i);
    sys_rst_i = 1'b0;
    #1;
    check("first_fetch_cyc", {wbc_cyc_o, wbc_stb_o}, 2'b11);
    check("first_fetch_adr", wbc_adr_o, 16'h0000);
    check("first_no_wbd", wbd_cyc_o, 1'b0);
    sys_rst_i = 1'b1;
    run(40);
    check("p1_sum", dd(0), 16'h0008);
    check("p1_sum_adr", da(0), 16'h0300);
    check("p1_depth", dd(1), 16'h0020);
    check("p1_depth_adr", da(1), 16'h0301);
    check("p1_3insn_6clk", fc(3) - fc(0), 6);
    check("p1_wr_count", d_adr.size(), 2);

    // Program 2: store 1234H to 0100H, read back, dump at 0200H
    clear_rom();
    emit(16'h9234); emit(16'h8100); emit(16'h6023);
    emit(16'h8100); emit(16'h6C00);
    emit_store(16'h0200);
    emit(16'h0007);
    run(40);
    check("p2_wr_adr", da(0), 16'h0100);
    check("p2_wr_we", dw(0), 1'b1);
    check("p2_wr_dat", dd(0), 16'h1234);
    check("p2_rd_adr", da(1), 16'h0100);
    check("p2_rd_we", dw(1), 1'b0);
    check("p2_rd_T", dd(2), 16'h1234);

    // Program 3: 0branch taken then not taken
    clear_rom();
    emit(16'h8000); emit(16'h2010);
    org(16'h10);
    emit(16'h8001); emit(16'h2030); emit(16'h0012);
    run(30);
    check("p3_fetch1", fa(1), 16'h0002);
    check("p3_taken", fa(2), 16'h0020);
    check("p3_fetch3", fa(3), 16'h0022);
    check("p3_fallthru", fa(4), 16'h0024);

    // Program 4: call 20H at pc 5, return via R->PC, dump depth
    clear_rom();
    emit(16'h0005);
    org(5);
    emit(16'h4020); emit(16'h6E00);
    emit_store(16'h0300);
    emit(16'h0009);
    org(16'h20);
    emit(16'h700C);
    run(40);
    check("p4_call_fetch", fa(2), 16'h0040);
    check("p4_ret_fetch", fa(3), 16'h000C);
    check("p4_depth_after_ret", dd(0), 16'h0000);

    // Program 5: slow I/O read at 4000H
    clear_rom();
    emit(16'hC000); emit(16'h6C00);
    emit_store(16'h0300);
    emit(16'h0004);
    io_delay = 3;
    run(40);
    io_delay = 0;
    check("p5_io_adr", da(0), 16'h4000);
    check("p5_io_we", dw(0), 1'b0);
    check("p5_io_held", io_cycles, 4);
    check("p5_io_T", dd(1), 16'hA5C3);

    // Program 6: ALU ops, each result stored at 0310H+k
    clear_rom();
    emit(16'h8F00); emit(16'h8004); emit(16'h6903); emit_store(16'h0310);
    emit(16'h8003); emit(16'h8004); emit(16'h6D03); emit_store(16'h0311);
    emit(16'h8005); emit(16'h6600); emit(16'h8002); emit(16'h6803); emit_store(16'h0312);
    emit(16'h8005); emit(16'h6600); emit(16'h8002); emit(16'h6F03); emit_store(16'h0313);
    emit(16'h8007); emit(16'h6A00); emit_store(16'h0314);
    emit(16'h8006); emit(16'h8006); emit(16'h6703); emit_store(16'h0315);
    emit(16'h8006); emit(16'h8005); emit(16'h6503); emit_store(16'h0316);
    emit(16'h8000 | 16'(rom_ptr + 1)); emit(16'h0000 | 16'(rom_ptr));
    run(150);
    check("alu_shr", dd(0), 16'h00F0);
    check("alu_shl", dd(1), 16'h0030);
    check("alu_lt_signed", dd(2), 16'hFFFF);
`ifdef J1_WB_UNSIGNED_LT_EN
    check("alu_opF", dd(3), 16'h0000);
`else
    check("alu_opF", dd(3), 16'hFFFF);
`endif
    check("alu_dec", dd(4), 16'h0006);
    check("alu_eq", dd(5), 16'hFFFF);
    check("alu_xor", dd(6), 16'h0003);
    check("alu_last_adr", da(6), 16'h0316);
    check("bus_overlap", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
